// File: rtl/aer_spike_serializer.sv
// aer_spike_serializer
//   Takes pooled output words from the convolution/pooling layer and queues
//   them in a small circular FIFO. Each spike mask is then sent out as one
//   address-event (AER) beat {x, y, channel} per set bit, on a valid/ready
//   stream. A word with the timestep flag set becomes a single marker beat.
//
// Optional feature (macro AER_EVENT_COUNT_EN):
//   When defined, adds spike_count (saturating count of accepted channel beats)
//   and timestep_count (wrapping count of accepted markers).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_data           {ts, x, y, spikes[OUT_CHANNELS-1:0]}
//   in_write_enable   write strobe for in_data
//   in_full_next      registered: occupancy >= BUFFER_DEPTH-1
//   out_valid/ready   AER beat handshake
//   out_x, out_y      event coordinate
//   out_channel       channel index (0 for markers)
//   out_is_timestep   beat is a timestep marker
//   overflow          sticky: a write was dropped because the buffer was full
//
// Handshake: a beat transfers on a rising clk edge where out_valid && out_ready.
// While out_valid=1 and out_ready=0 every out_* field holds; out_valid only
// falls after a transfer (or on reset).
module aer_spike_serializer #(
   parameter int OUT_CHANNELS        = 4,
   parameter int BITS_PER_COORDINATE = 8,
   parameter int BUFFER_DEPTH        = 4,
   localparam int CW  = BITS_PER_COORDINATE - 1,
   localparam int W   = 2 * CW + OUT_CHANNELS + 1,
   localparam int CHW = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [W-1:0]   in_data,
   input  logic           in_write_enable,
   output logic           in_full_next,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [CW-1:0]  out_x,
   output logic [CW-1:0]  out_y,
   output logic [CHW-1:0] out_channel,
   output logic           out_is_timestep,
   output logic           overflow
`ifdef AER_EVENT_COUNT_EN
   ,
   output logic [31:0]    spike_count,
   output logic [15:0]    timestep_count
`endif
);

   localparam int PW   = $clog2(BUFFER_DEPTH);
   localparam int CNTW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT} state_t;

   state_t                  state_q, state_d;
   logic [W-1:0]            mem_q [BUFFER_DEPTH];
   logic [W-1:0]            mem_d [BUFFER_DEPTH];
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]         count_q, count_d;
   logic                    full_next_q, full_next_d;
   logic                    overflow_q, overflow_d;
   logic                    ts_q, ts_d;
   logic [CW-1:0]           x_q, x_d, y_q, y_d;
   logic [OUT_CHANNELS-1:0] mask_q, mask_d;
   logic                    out_valid_q, out_valid_d;
   logic [CW-1:0]           out_x_q, out_x_d, out_y_q, out_y_d;
   logic [CHW-1:0]          out_channel_q, out_channel_d;
   logic                    out_is_ts_q, out_is_ts_d;

   logic         fifo_full, fifo_empty, push, pop, handshake;
   logic [W-1:0] head;

   // Index of the lowest set bit; scanning downward lets the lowest one win.
   function automatic logic [CHW-1:0] lowest_idx(input logic [OUT_CHANNELS-1:0] m);
      lowest_idx = '0;
      for (int i = OUT_CHANNELS - 1; i >= 0; i--) begin
         if (m[i]) lowest_idx = CHW'(i);
      end
   endfunction

   assign fifo_full  = (count_q == CNTW'(BUFFER_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign pop        = (state_q == S_IDLE) && !fifo_empty;
   // A pop in the same cycle frees a slot, so a write into a full buffer is
   // still accepted then.
   assign push       = in_write_enable && (!fifo_full || pop);
   assign handshake  = out_valid_q && out_ready;
   assign head       = mem_q[rd_ptr_q];

   // Buffer bookkeeping
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (in_write_enable && !push) overflow_d = 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_next_d = (count_d >= CNTW'(BUFFER_DEPTH - 1));
   end

   // Serializer FSM. mask_q holds the bits not yet presented, so the bit of
   // the beat currently on the bus is already cleared from it.
   always_comb begin
      state_d       = state_q;
      ts_d          = ts_q;
      x_d           = x_q;
      y_d           = y_q;
      mask_d        = mask_q;
      out_valid_d   = out_valid_q;
      out_x_d       = out_x_q;
      out_y_d       = out_y_q;
      out_channel_d = out_channel_q;
      out_is_ts_d   = out_is_ts_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               ts_d    = head[W-1];
               x_d     = head[W-2 -: CW];
               y_d     = head[OUT_CHANNELS+CW-1 -: CW];
               mask_d  = head[OUT_CHANNELS-1:0];
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (ts_q) begin
               out_valid_d   = 1'b1;
               out_is_ts_d   = 1'b1;
               out_channel_d = '0;
               out_x_d       = x_q;
               out_y_d       = y_q;
               mask_d        = '0;
               state_d       = S_EMIT;
            end else if (mask_q == '0) begin
               state_d = S_IDLE;
            end else begin
               out_valid_d   = 1'b1;
               out_is_ts_d   = 1'b0;
               out_channel_d = lowest_idx(mask_q);
               out_x_d       = x_q;
               out_y_d       = y_q;
               mask_d        = mask_q & (mask_q - 1'b1);
               state_d       = S_EMIT;
            end
         end
         S_EMIT: begin
            if (handshake) begin
               if (mask_q != '0) begin
                  out_channel_d = lowest_idx(mask_q);
                  out_is_ts_d   = 1'b0;
                  mask_d        = mask_q & (mask_q - 1'b1);
               end else begin
                  out_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         for (int i = 0; i < BUFFER_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         full_next_q   <= 1'b0;
         overflow_q    <= 1'b0;
         ts_q          <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         mask_q        <= '0;
         out_valid_q   <= 1'b0;
         out_x_q       <= '0;
         out_y_q       <= '0;
         out_channel_q <= '0;
         out_is_ts_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_q         <= mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         full_next_q   <= full_next_d;
         overflow_q    <= overflow_d;
         ts_q          <= ts_d;
         x_q           <= x_d;
         y_q           <= y_d;
         mask_q        <= mask_d;
         out_valid_q   <= out_valid_d;
         out_x_q       <= out_x_d;
         out_y_q       <= out_y_d;
         out_channel_q <= out_channel_d;
         out_is_ts_q   <= out_is_ts_d;
      end
   end

   assign in_full_next    = full_next_q;
   assign overflow        = overflow_q;
   assign out_valid       = out_valid_q;
   assign out_x           = out_x_q;
   assign out_y           = out_y_q;
   assign out_channel     = out_channel_q;
   assign out_is_timestep = out_is_ts_q;

`ifdef AER_EVENT_COUNT_EN
   logic [31:0] spike_count_q, spike_count_d;
   logic [15:0] ts_count_q, ts_count_d;

   always_comb begin
      spike_count_d = spike_count_q;
      ts_count_d    = ts_count_q;
      if (handshake) begin
         if (out_is_ts_q) ts_count_d = ts_count_q + 1'b1;
         else if (spike_count_q != '1) spike_count_d = spike_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spike_count_q <= '0;
         ts_count_q    <= '0;
      end else begin
         spike_count_q <= spike_count_d;
         ts_count_q    <= ts_count_d;
      end
   end

   assign spike_count    = spike_count_q;
   assign timestep_count = ts_count_q;
`endif

endmodule

// File: tb/tb_aer_spike_serializer.sv
// Testbench for aer_spike_serializer (OUT_CHANNELS=4, BITS_PER_COORDINATE=8,
// BUFFER_DEPTH=4). Inputs change 2 time units after the rising edge; outputs
// are sampled on the falling edge. The expected beat stream is built from
// each accepted word: one marker beat for a timestep word, otherwise one beat
// per set mask bit in ascending channel order.
module tb_aer_spike_serializer;
   localparam int OC = 4;
   localparam int BPC = 8;
   localparam int BD = 4;
   localparam int CW = BPC - 1;
   localparam int W = 2 * CW + OC + 1;
   localparam int BW = 1 + CW + CW + 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_write_enable = 1'b0;
   logic          in_full_next;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [CW-1:0] out_x, out_y;
   logic [1:0]    out_channel;
   logic          out_is_timestep;
   logic          overflow;
`ifdef AER_EVENT_COUNT_EN
   logic [31:0]   spike_count;
   logic [15:0]   timestep_count;
`endif

   aer_spike_serializer #(
      .OUT_CHANNELS(OC), .BITS_PER_COORDINATE(BPC), .BUFFER_DEPTH(BD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data),
      .in_write_enable(in_write_enable), .in_full_next(in_full_next),
      .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
      .out_y(out_y), .out_channel(out_channel),
      .out_is_timestep(out_is_timestep), .overflow(overflow)
`ifdef AER_EVENT_COUNT_EN
      , .spike_count(spike_count), .timestep_count(timestep_count)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   // scoreboard state
   int unsigned    n_vec = 0;
   int unsigned    n_err = 0;
   logic [BW-1:0]  exp_q[$];
   int unsigned    model_spikes = 0;
   int unsigned    model_marks = 0;
   logic           stall_pend = 1'b0;
   logic [BW-1:0]  stall_beat = '0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: expand one accepted word into its expected beats.
   task automatic model_word(input logic ts, input logic [CW-1:0] x,
                             input logic [CW-1:0] y, input logic [OC-1:0] m);
      if (ts) exp_q.push_back({1'b1, x, y, 2'd0});
      else
         for (int i = 0; i < OC; i++)
            if (m[i]) exp_q.push_back({1'b0, x, y, 2'(i)});
   endtask

   // monitor: beat comparison and stall stability
   always @(negedge clk) begin
      logic [BW-1:0] cur;
      logic [BW-1:0] e;
      cur = {out_is_timestep, out_x, out_y, out_channel};
      if (!rst_n) begin
         stall_pend = 1'b0;
      end else begin
         if (stall_pend) begin
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_fields", 64'(cur), 64'(stall_beat));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_beat", 64'(cur), 64'h1_0000_0000);
            end else begin
               e = exp_q.pop_front();
               check_eq("beat", 64'(cur), 64'(e));
               if (e[BW-1]) model_marks++;
               else model_spikes++;
            end
         end
         stall_pend = out_valid && !out_ready;
         stall_beat = cur;
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic write_word(input logic ts, input logic [CW-1:0] x,
                             input logic [CW-1:0] y, input logic [OC-1:0] m,
                             input bit accepted);
      in_data = {ts, x, y, m};
      in_write_enable = 1'b1;
      if (accepted) model_word(ts, x, y, m);
      tick();
      in_write_enable = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid) return;
      end
      check_eq(tag, 64'd0, 64'd1);
   endtask

   task automatic wait_drain();
      int quiet;
      quiet = 0;
      for (int i = 0; i < 2000 && quiet < 6; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid) quiet++;
         else quiet = 0;
      end
      check_eq("drain_left", 64'(exp_q.size()), 64'd0);
      tick();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      exp_q.delete();
      model_spikes = 0;
      model_marks = 0;
      #1;
      check_eq("rst_valid", 64'(out_valid), 64'd0);
      check_eq("rst_x", 64'(out_x), 64'd0);
      check_eq("rst_y", 64'(out_y), 64'd0);
      check_eq("rst_channel", 64'(out_channel), 64'd0);
      check_eq("rst_is_ts", 64'(out_is_timestep), 64'd0);
      check_eq("rst_overflow", 64'(overflow), 64'd0);
      check_eq("rst_full_next", 64'(in_full_next), 64'd0);
`ifdef AER_EVENT_COUNT_EN
      check_eq("rst_spike_count", 64'(spike_count), 64'd0);
      check_eq("rst_ts_count", 64'(timestep_count), 64'd0);
`endif
   endtask

   initial begin
      int lat;
      int gap;
      in_write_enable = 1'b0;
      out_ready = 1'b0;
      apply_reset();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      tick();

      // two-bit word: latency and back-to-back beats
      out_ready = 1'b1;
      write_word(1'b0, 7'd5, 7'd9, 4'b1010, 1'b1);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid) break;
      end
      check_eq("latency", 64'(lat), 64'd2);
      check_eq("first_ch", 64'(out_channel), 64'd1);
      @(negedge clk);
      check_eq("second_valid", 64'(out_valid), 64'd1);
      check_eq("second_ch", 64'(out_channel), 64'd3);
      @(negedge clk);
      check_eq("valid_drop", 64'(out_valid), 64'd0);
      wait_drain();

      // timestep marker ignores spike bits
      write_word(1'b1, 7'd0, 7'd0, 4'b1111, 1'b1);
      wait_drain();

      // empty mask word is dropped silently
      write_word(1'b0, 7'd3, 7'd3, 4'b0000, 1'b1);
      write_word(1'b0, 7'd1, 7'd2, 4'b0001, 1'b1);
      wait_drain();

      // exactly two idle cycles between words
      write_word(1'b0, 7'd2, 7'd2, 4'b0001, 1'b1);
      write_word(1'b0, 7'd4, 7'd4, 4'b0001, 1'b1);
      wait_valid("gap_first_timeout");
      gap = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) break;
         gap++;
      end
      check_eq("word_gap", 64'(gap), 64'd2);
      wait_drain();

      // stall with ready low for 5 cycles
      out_ready = 1'b0;
      write_word(1'b0, 7'd6, 7'd7, 4'b1111, 1'b1);
      wait_valid("stall_valid_timeout");
      repeat (5) @(posedge clk);
      #2;
      check_eq("stall_valid", 64'(out_valid), 64'd1);
      check_eq("stall_ch", 64'(out_channel), 64'd0);
      out_ready = 1'b1;
      wait_drain();

      // fill the buffer behind a stalled beat, then overflow
      out_ready = 1'b0;
      write_word(1'b0, 7'd10, 7'd11, 4'b0001, 1'b1);
      wait_valid("ovf_valid_timeout");
      tick();
      write_word(1'b0, 7'd20, 7'd21, 4'b0011, 1'b1);
      write_word(1'b1, 7'd22, 7'd23, 4'b0000, 1'b1);
      check_eq("full_next_two", 64'(in_full_next), 64'd0);
      write_word(1'b0, 7'd24, 7'd25, 4'b1000, 1'b1);
      check_eq("full_next_three", 64'(in_full_next), 64'd1);
      write_word(1'b0, 7'd26, 7'd27, 4'b0101, 1'b1);
      check_eq("overflow_before", 64'(overflow), 64'd0);
      write_word(1'b0, 7'd28, 7'd29, 4'b1111, 1'b0);
      check_eq("overflow_set", 64'(overflow), 64'd1);
      out_ready = 1'b1;
      wait_drain();
      check_eq("overflow_sticky", 64'(overflow), 64'd1);
      check_eq("full_next_clear", 64'(in_full_next), 64'd0);

      // reset during the second beat of a 3-bit word
      write_word(1'b0, 7'd12, 7'd13, 4'b0111, 1'b1);
      wait_valid("rst_valid_timeout");
      @(posedge clk);
      #2;
      apply_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (20) tick();
      check_eq("post_rst_valid", 64'(out_valid), 64'd0);
      check_eq("post_rst_full_next", 64'(in_full_next), 64'd0);
      write_word(1'b0, 7'd30, 7'd31, 4'b1001, 1'b1);
      wait_drain();

      // randomized traffic; only write when a slot is guaranteed free
      for (int n = 0; n < 600; n++) begin
         logic ts;
         logic [CW-1:0] x, y;
         logic [OC-1:0] m;
         out_ready = ($urandom_range(0, 9) < 7);
         if (!in_full_next && $urandom_range(0, 1) == 1) begin
            ts = ($urandom_range(0, 7) == 0);
            x = CW'($urandom_range(0, 127));
            y = CW'($urandom_range(0, 127));
            m = OC'($urandom_range(0, 15));
            in_data = {ts, x, y, m};
            in_write_enable = 1'b1;
            model_word(ts, x, y, m);
         end else begin
            in_write_enable = 1'b0;
         end
         tick();
      end
      in_write_enable = 1'b0;
      out_ready = 1'b1;
      wait_drain();
      check_eq("rand_overflow", 64'(overflow), 64'd0);
`ifdef AER_EVENT_COUNT_EN
      check_eq("spike_count", 64'(spike_count), 64'(model_spikes));
      check_eq("timestep_count", 64'(timestep_count), 64'(model_marks));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
